fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined core. It owns the program counter and drives it into the instruction ROM as a word index. It registers the returned instruction together with its PC into the IF/ID pipeline register. It handles start/halt sequencing, decode stalls, branch redirects, pipeline flushes and out-of-range fetch faults.

---
 rtl/fetch_stage.sv | 178 +++++++++++++++++
 tb/tb_fetch_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage. Owns the program counter, drives it to the
//   instruction ROM as a word index, and registers the returned instruction
//   plus its PC into the IF/ID pipeline register. Handles start/halt
//   sequencing, decode stalls, branch redirects, flushes and out-of-range
//   redirect faults.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle pulse; (re)start fetching from PC 0
//   stall               hold PC and IF/ID (decode back-pressure)
//   flush               replace IF/ID contents with a bubble
//   branch_taken        redirect fetch to branch_target
//   branch_target [N]   word index of redirect target
//   pc [N]              registered fetch address to the ROM
//   instruction [N]     combinational ROM read data for pc
//   if_id_instruction   registered instruction to decode
//   if_id_pc            PC of if_id_instruction
//   if_id_valid         IF/ID holds a real instruction
//   done                program end reached, fetching stopped
//   pc_fault            sticky; a redirect targeted PC >= INS

module fetch_stage #(
  parameter int unsigned N   = 32,
  parameter int unsigned INS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stall,
  input  logic         flush,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  output logic [N-1:0] pc,
  input  logic [N-1:0] instruction,
  output logic [N-1:0] if_id_instruction,
  output logic [N-1:0] if_id_pc,
  output logic         if_id_valid,
  output logic         done,
  output logic         pc_fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [N-1:0] INS_W   = N'(INS);
  localparam logic [N-1:0] LAST_PC = N'(INS - 1);
  localparam logic [N-1:0] ONE     = N'(1);

  state_e       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] if_id_instruction_q, if_id_instruction_d;
  logic [N-1:0] if_id_pc_q, if_id_pc_d;
  logic         if_id_valid_q, if_id_valid_d;
  logic         done_q, done_d;
  logic         pc_fault_q, pc_fault_d;

  logic target_ok;
  logic at_last;
  logic advance;

  assign target_ok = (branch_target < INS_W);
  assign at_last   = (pc_q == LAST_PC);
  // A flush advances the PC exactly like a normal fetch; only the IF/ID
  // capture is replaced by a bubble. Stall holds only when neither applies.
  assign advance   = flush || !stall;

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q             <= IDLE;
      pc_q                <= '0;
      if_id_instruction_q <= '0;
      if_id_pc_q          <= '0;
      if_id_valid_q       <= 1'b0;
      done_q              <= 1'b0;
      pc_fault_q          <= 1'b0;
    end else begin
      state_q             <= state_d;
      pc_q                <= pc_d;
      if_id_instruction_q <= if_id_instruction_d;
      if_id_pc_q          <= if_id_pc_d;
      if_id_valid_q       <= if_id_valid_d;
      done_q              <= done_d;
      pc_fault_q          <= pc_fault_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          if (branch_taken) begin
            state_d = target_ok ? RUN : DONE;
          end else if (advance && at_last) begin
            state_d = DONE;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    pc_d                = pc_q;
    if_id_instruction_d = if_id_instruction_q;
    if_id_pc_d          = if_id_pc_q;
    if_id_valid_d       = if_id_valid_q;
    done_d              = done_q;
    pc_fault_d          = pc_fault_q;

    if (start) begin
      pc_d                = '0;
      if_id_instruction_d = '0;
      if_id_pc_d          = '0;
      if_id_valid_d       = 1'b0;
      done_d              = 1'b0;
      pc_fault_d          = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        RUN: begin
          if (branch_taken) begin
            if_id_instruction_d = '0;
            if_id_pc_d          = '0;
            if_id_valid_d       = 1'b0;
            if (target_ok) begin
              pc_d = branch_target;
            end else begin
              pc_fault_d = 1'b1;
              done_d     = 1'b1;
            end
          end else if (advance) begin
            if (flush) begin
              if_id_instruction_d = '0;
              if_id_pc_d          = '0;
              if_id_valid_d       = 1'b0;
            end else begin
              if_id_instruction_d = instruction;
              if_id_pc_d          = pc_q;
              if_id_valid_d       = 1'b1;
            end
            if (at_last) begin
              done_d = 1'b1;
            end else begin
              pc_d = pc_q + ONE;
            end
          end
        end
        DONE: begin
          if_id_instruction_d = '0;
          if_id_pc_d          = '0;
          if_id_valid_d       = 1'b0;
          done_d              = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc                = pc_q;
  assign if_id_instruction = if_id_instruction_q;
  assign if_id_pc          = if_id_pc_q;
  assign if_id_valid       = if_id_valid_q;
  assign done              = done_q;
  assign pc_fault          = pc_fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int unsigned N   = 32;
  localparam int unsigned INS = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, stall, flush, branch_taken;
  logic [N-1:0] branch_target;
  logic [N-1:0] pc;
  logic [N-1:0] instruction;
  logic [N-1:0] if_id_instruction;
  logic [N-1:0] if_id_pc;
  logic         if_id_valid;
  logic         done;
  logic         pc_fault;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // ROM model: distinct word per address
  assign instruction = 32'hC0DE_0000 + pc;

  fetch_stage #(.N(N), .INS(INS)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .stall             (stall),
    .flush             (flush),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .pc                (pc),
    .instruction       (instruction),
    .if_id_instruction (if_id_instruction),
    .if_id_pc          (if_id_pc),
    .if_id_valid       (if_id_valid),
    .done              (done),
    .pc_fault          (pc_fault)
  );

  typedef struct {
    logic        start;
    logic        stall;
    logic        flush;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic [31:0] e_ifpc;
    logic        e_valid;
    logic        e_done;
    logic        e_fault;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [31:0] e_pc, input logic [31:0] e_ifpc,
                         input logic e_valid, input logic e_done, input logic e_fault);
    logic [31:0] e_ins;
    e_ins = e_valid ? (32'hC0DE_0000 + e_ifpc) : 32'h0;
    chk("pc",       idx, pc,                e_pc);
    chk("if_id_pc", idx, if_id_pc,          e_ifpc);
    chk("valid",    idx, {31'b0, if_id_valid}, {31'b0, e_valid});
    chk("done",     idx, {31'b0, done},     {31'b0, e_done});
    chk("pc_fault", idx, {31'b0, pc_fault}, {31'b0, e_fault});
    chk("if_id_ins", idx, if_id_instruction, e_ins);
  endtask

  function automatic vec_t v(input logic s, input logic st, input logic fl, input logic b,
                             input int t, input int epc, input int eifpc,
                             input logic ev, input logic ed, input logic ef);
    vec_t r;
    r.start = s; r.stall = st; r.flush = fl; r.br = b; r.tgt = t;
    r.e_pc = epc; r.e_ifpc = eifpc; r.e_valid = ev; r.e_done = ed; r.e_fault = ef;
    return r;
  endfunction

  task automatic drive(input logic s, input logic st, input logic fl, input logic b, input int t);
    start = s; stall = st; flush = fl; branch_taken = b; branch_target = t;
  endtask

  initial begin
    //                s  st fl br tgt  pc ifpc v  d  f
    vecs.push_back(v(1, 0, 0, 0, 0,   0, 0,  0, 0, 0)); // start
    vecs.push_back(v(0, 0, 0, 0, 0,   1, 0,  1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0,   2, 1,  1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0,   3, 2,  1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0,   4, 3,  1, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0,   4, 3,  1, 0, 0)); // stall x3
    vecs.push_back(v(0, 1, 0, 0, 0,   4, 3,  1, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0,   4, 3,  1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0,   5, 4,  1, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0,   6, 0,  0, 0, 0)); // flush at pc=5
    vecs.push_back(v(0, 0, 0, 0, 0,   7, 6,  1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0,   8, 7,  1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0,   9, 8,  1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0,   9, 9,  1, 1, 0)); // last word, done
    vecs.push_back(v(0, 0, 0, 0, 0,   9, 0,  0, 1, 0)); // bubble in DONE
    vecs.push_back(v(0, 1, 1, 1, 3,   9, 0,  0, 1, 0)); // ignored in DONE
    vecs.push_back(v(1, 0, 0, 0, 0,   0, 0,  0, 0, 0)); // restart
    vecs.push_back(v(0, 0, 0, 0, 0,   1, 0,  1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0,   2, 1,  1, 0, 0));
    vecs.push_back(v(0, 1, 0, 1, 7,   7, 0,  0, 0, 0)); // branch overrides stall
    vecs.push_back(v(0, 0, 0, 0, 0,   8, 7,  1, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 12,  8, 0,  0, 1, 1)); // out-of-range fault
    vecs.push_back(v(0, 0, 0, 0, 0,   8, 0,  0, 1, 1));
    vecs.push_back(v(1, 0, 0, 0, 0,   0, 0,  0, 0, 0)); // start clears fault
    vecs.push_back(v(0, 0, 0, 0, 0,   1, 0,  1, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 0,   0, 0,  0, 0, 0)); // restart in RUN
    vecs.push_back(v(0, 0, 0, 0, 0,   1, 0,  1, 0, 0));
    vecs.push_back(v(0, 0, 1, 1, 3,   3, 0,  0, 0, 0)); // branch beats flush
    vecs.push_back(v(0, 0, 0, 1, 10,  3, 0,  0, 1, 1)); // target == INS faults
    vecs.push_back(v(1, 0, 0, 1, 12,  0, 0,  0, 0, 0)); // start beats branch
    vecs.push_back(v(0, 0, 0, 0, 0,   1, 0,  1, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 9,   9, 0,  0, 0, 0)); // target INS-1 legal
    vecs.push_back(v(0, 0, 0, 0, 0,   9, 9,  1, 1, 0));
    vecs.push_back(v(0, 0, 1, 0, 0,   9, 0,  0, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 0,   0, 0,  0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0,   1, 0,  1, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 8,   8, 0,  0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0,   9, 8,  1, 0, 0));
    vecs.push_back(v(0, 1, 1, 0, 0,   9, 0,  0, 1, 0)); // flush at last pc -> DONE

    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk_all(-1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // IDLE ignores everything but start
    drive(0, 1, 1, 1, 5);
    @(posedge clk); #1;
    chk_all(-2, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].start, vecs[i].stall, vecs[i].flush, vecs[i].br, vecs[i].tgt);
      @(posedge clk); #1;
      chk_all(i, vecs[i].e_pc, vecs[i].e_ifpc, vecs[i].e_valid, vecs[i].e_done, vecs[i].e_fault);
    end

    // Async reset mid-RUN at pc=6
    @(negedge clk);
    drive(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    repeat (6) @(posedge clk);
    #1;
    chk_all(100, 6, 5, 1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_all(101, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all(102, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_all(103, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_all(104, 1, 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
